// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_W'(5)) d_o = d_i + BCD_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      out_valid,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      ovf
);

  localparam int unsigned BCD_TOT = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

  state_e               state_q;
  logic [BIN_W-1:0]     shreg_q, shreg_d;
  logic [BCD_TOT-1:0]   scratch_q, scratch_d, adj;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_acc_q, carry_d;
  logic                 out_valid_q;
  logic [BCD_TOT-1:0]   bcd_q;
  logic                 ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (scratch_q[g*BCD_W +: BCD_W]),
      .d_o (adj[g*BCD_W +: BCD_W])
    );
  end

  // The bit leaving the top digit is the overflow carry.
  always_comb begin
    {carry_d, scratch_d, shreg_d} = {adj, shreg_q, 1'b0};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shreg_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            ovf_acc_q <= 1'b0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_q   <= shreg_d;
          scratch_q <= scratch_d;
          ovf_acc_q <= ovf_acc_q | carry_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          // Results and the valid pulse are registered together on leaving DONE.
          bcd_q       <= scratch_q;
          ovf_q       <= ovf_acc_q;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq (3-digit and 2-digit instances) against a decimal model.
module tb_bin2bcd_seq;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        iv_a, rdy_a, ov_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic        iv_b, rdy_b, ov_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] prev_a = '0;
  logic [7:0]  prev_b = '0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clock(clk), .resetn(rstn), .in_valid(iv_a), .in_ready(rdy_a), .bin_in(bin_a),
    .out_valid(ov_a), .bcd_out(bcd_a), .ovf(ovf_a));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clock(clk), .resetn(rstn), .in_valid(iv_b), .in_ready(rdy_b), .bin_in(bin_b),
    .out_valid(ov_b), .bcd_out(bcd_b), .ovf(ovf_b));

  // Returns {ovf, packed BCD}: decimal digits by repeated division.
  function automatic logic [12:0] model(input int v, input int digits);
    logic [11:0] b;
    int r;
    b = '0;
    r = v;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {(r != 0), b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input int which, input int v, input string tag);
    logic [12:0] m;
    int lat;
    bit busy_ok, stable_ok;
    logic        rdy, ov, of;
    logic [11:0] bcd, prev;
    m = model(v, which ? 2 : 3);
    prev = which ? {4'h0, prev_b} : prev_a;
    @(negedge clk);
    for (int i = 0; i < 40 && !(which ? rdy_b : rdy_a); i++) @(negedge clk);
    check({tag, "_ready"}, 32'(which ? rdy_b : rdy_a), 32'd1);
    if (which) begin iv_b = 1'b1; bin_b = 8'(v); end
    else       begin iv_a = 1'b1; bin_a = 8'(v); end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      rdy = which ? rdy_b : rdy_a;
      ov  = which ? ov_b : ov_a;
      bcd = which ? {4'h0, bcd_b} : bcd_a;
      if (ov) begin lat = n; break; end
      if (rdy) busy_ok = 1'b0;
      if (bcd !== prev) stable_ok = 1'b0;
    end
    of  = which ? ovf_b : ovf_a;
    bcd = which ? {4'h0, bcd_b} : bcd_a;
    check({tag, "_latency"}, 32'(lat), 32'(BW + 1));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_bcd"}, 32'(bcd), 32'(m[11:0]));
    check({tag, "_ovf"}, 32'(of), 32'(m[12]));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(which ? ov_b : ov_a), 32'd0);
    if (which) prev_b = m[7:0];
    else       prev_a = m[11:0];
  endtask

  initial begin
    int p1, p2, seen;
    bit busy_ok, no_pulse;
    logic [12:0] m;
    rstn = 1'b1; iv_a = 1'b0; iv_b = 1'b0; bin_a = '0; bin_b = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_ready", 32'(rdy_a), 32'd1);
    check("rst_valid", 32'(ov_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    run_conv(0, 0, "zero");
    run_conv(0, 255, "v255");
    run_conv(0, 99, "v99");
    run_conv(0, 100, "v100");

    // Back-to-back: in_valid held across two acceptances.
    @(negedge clk);
    iv_a = 1'b1; bin_a = 8'd37;
    @(posedge clk);
    #1 bin_a = 8'd200;
    p1 = -1; p2 = -1; busy_ok = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (n == 10) iv_a = 1'b0;
      if (ov_a) begin
        if (p1 < 0) begin
          p1 = n;
          check("b2b_first", 32'(bcd_a), 32'h037);
        end else begin
          p2 = n;
          check("b2b_second", 32'(bcd_a), 32'h200);
          break;
        end
      end
      if ((n < 9 || (n >= 10 && n < 19)) && rdy_a) busy_ok = 1'b0;
    end
    iv_a = 1'b0;
    check("b2b_first_lat", 32'(p1), 32'd9);
    check("b2b_spacing", 32'(p2 - p1), 32'd10);
    check("b2b_busy", 32'(busy_ok), 32'd1);
    prev_a = 12'h200;

    // Request during SHIFT is ignored.
    @(negedge clk);
    iv_a = 1'b1; bin_a = 8'd7;
    @(posedge clk);
    #1 iv_a = 1'b0;
    seen = 0;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (n == 3) begin iv_a = 1'b1; bin_a = 8'd42; end
      if (n == 4) iv_a = 1'b0;
      if (ov_a) begin
        seen++;
        check("ignore_bcd", 32'(bcd_a), 32'h007);
      end
    end
    check("ignore_count", 32'(seen), 32'd1);
    prev_a = 12'h007;

    // Reset mid-SHIFT aborts conversion.
    @(negedge clk);
    iv_a = 1'b1; bin_a = 8'd123;
    @(posedge clk);
    #1 iv_a = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(rdy_a), 32'd1);
    check("midrst_bcd", 32'(bcd_a), 32'd0);
    check("midrst_valid", 32'(ov_a), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    no_pulse = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (ov_a) no_pulse = 1'b0;
    end
    check("midrst_nopulse", 32'(no_pulse), 32'd1);
    prev_a = '0;
    prev_b = '0;

    // Two-digit instance: overflow and recovery.
    run_conv(1, 123, "d2_123");
    run_conv(1, 45, "d2_45");

    for (int i = 0; i < 15; i++) begin
      run_conv(0, int'($urandom_range(0, 255)), "rand3");
      run_conv(1, int'($urandom_range(0, 255)), "rand2");
    end

    m = model(255, 2);
    run_conv(1, 255, "d2_255");
    check("d2_255_model_ovf", 32'(ovf_b), 32'(m[12]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
